// File: rtl/dp_pkg.sv
// Shared types and sizes for the 16-bit processor datapath.
// Holds the ALU function encoding and the data/address widths used across the slice.
package dp_pkg;

  localparam int DW    = 16;
  localparam int RF_AW = $clog2(16);
  localparam int DM_AW = 8;

  typedef enum logic [2:0] {
    ALU_ZERO = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_PASS = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_AND  = 3'd6,
    ALU_INC  = 3'd7
  } alu_op_t;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two combinational read ports, one write port, synchronous clear (DP_RF_BYPASS_EN adds write-through).
// Latency: reads 0 cycles, write visible after the write edge.
// Backpressure: none; every control input is sampled on every edge.
module dp_regfile
  import dp_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     W_en,
  input  logic [$clog2(DEPTH)-1:0] W_Addr,
  input  logic [DW-1:0]            W_Data,
  input  logic [$clog2(DEPTH)-1:0] Ra_Addr,
  input  logic [$clog2(DEPTH)-1:0] Rb_Addr,
  output logic [DW-1:0]            Q_A,
  output logic [DW-1:0]            Q_B
);

  logic [DW-1:0] regs [DEPTH];

  // Reset clears every entry and wins over a write presented on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (W_en) begin
      regs[W_Addr] <= W_Data;
    end
  end

`ifdef DP_RF_BYPASS_EN
  assign Q_A = (W_en && (W_Addr == Ra_Addr)) ? W_Data : regs[Ra_Addr];
  assign Q_B = (W_en && (W_Addr == Rb_Addr)) ? W_Data : regs[Rb_Addr];
`else
  assign Q_A = regs[Ra_Addr];
  assign Q_B = regs[Rb_Addr];
`endif

endmodule

// File: rtl/proc_datapath.sv
// Execution datapath: register file, 8-function ALU and 256-word synchronous data memory (DP_RF_BYPASS_EN selects RF bypass).
// Latency: register read and ALU 0 cycles, memory read 1 cycle (read-first on same-address write).
// Backpressure: none; the control word is consumed every cycle.
module proc_datapath
  import dp_pkg::*;
#(
  parameter int DW       = 16,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [DM_AW-1:0]            D_Addr,
  input  logic                        D_Wr,
  input  logic                        RF_s,
  input  logic                        RF_W_en,
  input  logic [$clog2(RF_DEPTH)-1:0] RF_W_Addr,
  input  logic [$clog2(RF_DEPTH)-1:0] RF_Ra_Addr,
  input  logic [$clog2(RF_DEPTH)-1:0] RF_Rb_Addr,
  input  logic [2:0]                  ALU_s0,
  output logic [DW-1:0]               Q_A,
  output logic [DW-1:0]               Q_B,
  output logic [DW-1:0]               Mem_Q,
  output logic [DW-1:0]               ALU_Out,
  output logic                        ALU_Zero
);

  logic [DW-1:0] rf_w_data;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] dm [DM_DEPTH];

  assign rf_w_data = RF_s ? Mem_Q : alu_res;

  dp_regfile #(
    .DW    (DW),
    .DEPTH (RF_DEPTH)
  ) u_regfile (
    .Clk     (Clk),
    .Reset   (Reset),
    .W_en    (RF_W_en),
    .W_Addr  (RF_W_Addr),
    .W_Data  (rf_w_data),
    .Ra_Addr (RF_Ra_Addr),
    .Rb_Addr (RF_Rb_Addr),
    .Q_A     (Q_A),
    .Q_B     (Q_B)
  );

  // Unsigned, modulo 2^DW: carries and borrows fall off the top.
  always_comb begin
    alu_res = '0;
    case (alu_op_t'(ALU_s0))
      ALU_ZERO: alu_res = '0;
      ALU_ADD:  alu_res = Q_A + Q_B;
      ALU_SUB:  alu_res = Q_A - Q_B;
      ALU_PASS: alu_res = Q_A;
      ALU_XOR:  alu_res = Q_A ^ Q_B;
      ALU_OR:   alu_res = Q_A | Q_B;
      ALU_AND:  alu_res = Q_A & Q_B;
      ALU_INC:  alu_res = Q_A + DW'(1);
      default:  alu_res = '0;
    endcase
  end

  assign ALU_Out  = alu_res;
  assign ALU_Zero = (alu_res == '0);

  // Array contents survive reset; only the write is blocked on a reset edge.
  always_ff @(posedge Clk) begin
    if (D_Wr && !Reset) begin
      dm[D_Addr] <= Q_A;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Mem_Q <= '0;
    end else begin
      Mem_Q <= dm[D_Addr];
    end
  end

endmodule
